ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 120, giving the clk cycles the PS/2 clock is held low before request-to-send (at least 100 us).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the maximum clk cycles allowed between consecutive device clock falling edges.
REQ-003 clk  input  1  system clock; sole clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk__  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_data__  input  1  raw PS/2 data line, asynchronous.
REQ-007 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-008 ps2_data_oe  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-009 sys_adr  input  16  CPU address bus.
REQ-010 sys_rw  input  1  CPU read/write; 1 = read, 0 = write.
REQ-011 sys_data_in  input  8  CPU write data.
REQ-012 sys_data_out  output  8  CPU read data, registered; 8'hZZ when not selected.
REQ-013 sys_irq  output  1  active-low interrupt, asserted while done or failed is set.
REQ-014 tx_active  output  1  high in every state except IDLE; the receiver uses it to ignore bus activity.

Function
REQ-015 SHALL double-register ps2_clk__ and ps2_data__ into clk; all protocol logic uses only the synchronized copies.
REQ-016 SHALL be selected when sys_adr[15:13] == 3'b011 (0x6000-0x7FFF); register select rs = sys_adr[0]: 0 = STATUS, 1 = DATA.
REQ-017 STATUS read value SHALL be {busy, done, failed, timeout, 4'b0000}; busy equals tx_active.
REQ-018 DATA read value SHALL be the last byte written for transmission.
REQ-019 A write strobe SHALL be the first clk cycle of (select & ~sys_rw), detected against the previous cycle's value; a held write acts only once.
REQ-020 DATA write strobe in IDLE SHALL latch sys_data_in, compute odd parity (~^data), clear done/failed/timeout and enter INHIBIT the next cycle.
REQ-021 DATA write strobe while not IDLE SHALL be ignored: latched byte and state are unchanged.
REQ-022 STATUS write strobe SHALL clear done, failed and timeout in any state.
REQ-023 IDLE: ps2_clk_oe = 0 and ps2_data_oe = 0.
REQ-024 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-025 RTS: for 1 cycle, ps2_data_oe = 1 and ps2_clk_oe = 1; then go to BITS with ps2_clk_oe = 0, ps2_data_oe held at 1, and bit counter = 0.
REQ-026 BITS, on each synchronized clock falling edge:
 - counter 0-7: ps2_data_oe = ~data[counter], LSB first.
 - counter 8: ps2_data_oe = ~parity.
 - counter 9: ps2_data_oe = 0 (stop bit, released).
 - then counter increments; after counter 9, go to ACK.
REQ-027 ACK: on the next falling edge, sample data; low = acknowledged, go to WAIT_IDLE; high = set failed, go to WAIT_IDLE.
REQ-028 WAIT_IDLE: when synchronized clock and data are both high, go to IDLE; set done if failed is clear.
REQ-029 A timeout counter SHALL reset on entry to BITS and on every falling edge, and increment otherwise in BITS, ACK and WAIT_IDLE.
REQ-030 Reaching TIMEOUT_CYCLES SHALL release both lines, set timeout, and go to IDLE; done stays clear.
REQ-031 A falling edge and the timeout limit in the same cycle: the edge wins and the counter resets.
REQ-032 Flag set and STATUS write strobe in the same cycle: the set wins.

Reset
REQ-033 On reset, in any state, SHALL within 1 cycle:
 - go to IDLE with ps2_clk_oe = ps2_data_oe = 0;
 - clear done, failed, timeout, the bit counter and the timeout counter;
 - set the latched byte to 8'h00 and drive sys_data_out = 8'hZZ;
 - drive sys_irq = 1 and tx_active = 0.
REQ-034 Reset mid-transmission SHALL abandon the frame with no flag set.

Verification
REQ-035 Write 0xED to 0x6001 with a device model acking -> clock held low for 120 cycles; data bits 1,0,1,1,0,1,1,1, then parity 1, then stop; done = 1, STATUS = 8'h40, sys_irq = 0.
REQ-036 Write 0xF4 with the device model not driving ACK -> failed = 1, done = 0, STATUS = 8'h20, sys_irq = 0.
REQ-037 Write 0xFF, device gives 4 clocks then stops -> after 20000 cycles both oe = 0, STATUS = 8'h10, tx_active = 0.
REQ-038 Second DATA write of 0x00 during BITS -> transmitted byte stays 0xED, DATA reads 0xED; write to 0x6000 afterwards -> STATUS = 8'h00, sys_irq = 1.
REQ-039 Assert reset at bit counter 5 -> next cycle both oe = 0, tx_active = 0, STATUS = 8'h00.
REQ-040 Hold write select for 10 cycles on 0x6001 -> exactly one frame is sent.

Source files
------------

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a two-register CPU window (STATUS, DATA).
// Drives open-drain enables for the PS/2 clock and data lines; the device supplies the bit clock.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 120,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk__,
    input  logic        ps2_data__,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    input  logic [15:0] sys_adr,
    input  logic        sys_rw,
    input  logic [7:0]  sys_data_in,
    output logic [7:0]  sys_data_out,
    output logic        sys_irq,
    output logic        tx_active
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_prev_q;
    logic             wr_sel_q, rd_en_q;
    logic [7:0]       rd_data_q, data_q;
    logic             parity_q, done_q, failed_q, timeout_q;
    logic             clk_oe_q, data_oe_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic       ps2_clk_s, ps2_data_s, fall_d;
    logic       sel_d, wr_stb_d, to_expired_d;
    logic [7:0] status_d;
    logic       unused_adr_bits;

    assign ps2_clk_s    = clk_sync_q[1];
    assign ps2_data_s   = data_sync_q[1];
    assign fall_d       = clk_prev_q & ~ps2_clk_s;
    assign sel_d        = (sys_adr[15:13] == 3'b011);
    assign wr_stb_d     = sel_d & ~sys_rw & ~wr_sel_q;
    assign to_expired_d = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign status_d     = {tx_active, done_q, failed_q, timeout_q, 4'b0000};
    assign unused_adr_bits = ^sys_adr[12:1];

    // NOTE: every register below is assigned with <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            wr_sel_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_data_q   <= 8'h00;
            data_q      <= 8'h00;
            parity_q    <= 1'b0;
            done_q      <= 1'b0;
            failed_q    <= 1'b0;
            timeout_q   <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            inh_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk__};
            data_sync_q <= {data_sync_q[0], ps2_data__};
            clk_prev_q  <= ps2_clk_s;
            wr_sel_q    <= sel_d & ~sys_rw;
            rd_en_q     <= sel_d & sys_rw;
            rd_data_q   <= sys_adr[0] ? data_q : status_d;

            // Flag sets further down are later assignments, so they win over this clear.
            if (wr_stb_d && !sys_adr[0]) begin
                done_q    <= 1'b0;
                failed_q  <= 1'b0;
                timeout_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (wr_stb_d && sys_adr[0]) begin
                        data_q    <= sys_data_in;
                        parity_q  <= ~^sys_data_in;
                        done_q    <= 1'b0;
                        failed_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        inh_cnt_q <= '0;
                        clk_oe_q  <= 1'b1;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                        state_q   <= S_RTS;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end
                S_RTS: begin
                    clk_oe_q  <= 1'b0;
                    bit_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    state_q   <= S_BITS;
                end
                default: begin
                    to_cnt_q <= fall_d ? '0 : to_cnt_q + 1'b1;
                    if (!fall_d && to_expired_d) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (state_q == S_BITS) begin
                        if (fall_d) begin
                            if (bit_cnt_q < 4'd8)       data_oe_q <= ~data_q[bit_cnt_q[2:0]];
                            else if (bit_cnt_q == 4'd8) data_oe_q <= ~parity_q;
                            else                        data_oe_q <= 1'b0;
                            if (bit_cnt_q == 4'd9) state_q <= S_ACK;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall_d) begin
                            if (ps2_data_s) failed_q <= 1'b1;
                            state_q <= S_WAIT_IDLE;
                        end
                    end else if (ps2_clk_s && ps2_data_s) begin
                        if (!failed_q) done_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign sys_data_out = rd_en_q ? rd_data_q : 8'hzz;
    assign sys_irq      = ~(done_q | failed_q);
    assign tx_active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocks frames out of the host and
// the received bits are compared with frames built arithmetically from the written byte.
module tb_ps2_tx;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk__, ps2_data__;
    logic        ps2_clk_oe, ps2_data_oe;
    logic [15:0] sys_adr = 16'h0000;
    logic        sys_rw = 1'b1;
    logic [7:0]  sys_data_in = 8'h00;
    logic [7:0]  sys_data_out;
    logic        sys_irq, tx_active;
    logic        dev_clk_low = 1'b0, dev_data_low = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Open-drain bus: a line is high unless the host or the device pulls it low.
    assign ps2_clk__  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data__ = ~ps2_data_oe & ~dev_data_low;

    ps2_tx dut (
        .clk(clk), .reset(reset),
        .ps2_clk__(ps2_clk__), .ps2_data__(ps2_data__),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .sys_adr(sys_adr), .sys_rw(sys_rw), .sys_data_in(sys_data_in),
        .sys_data_out(sys_data_out), .sys_irq(sys_irq), .tx_active(tx_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected line levels as seen by the device: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones = 0;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Whenever the host is idle it must have both lines released.
    always @(negedge clk) begin
        if (!reset && !tx_active)
            check("idle_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        sys_adr = a; sys_rw = 1'b0; sys_data_in = d;
        @(negedge clk);
        sys_rw = 1'b1; sys_adr = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        sys_adr = a; sys_rw = 1'b1;
        @(negedge clk);
        d = sys_data_out;
        sys_adr = 16'h0000;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (tx_active && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_active) check("wait_idle_bound", 32'd1, 32'd0);
    endtask

    task automatic measure_inhibit(output int inh, output int rts);
        inh = 0; rts = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
            @(negedge clk);
            inh++;
        end
        while (ps2_clk_oe && ps2_data_oe && rts < 1000) begin
            @(negedge clk);
            rts++;
        end
    endtask

    // Device: waits for request-to-send, then issues nclk clocks (11 = full frame incl. ack clock).
    task automatic dev_frame(input int nclk, input bit do_ack, input int wr_at, input int rst_at,
                             output logic [9:0] got);
        int w = 0;
        got = '0;
        while (!(tx_active && !ps2_clk_oe && ps2_data_oe) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            check("rts_bound", 32'd1, 32'd0);
            return;
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 10 && k < nclk; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            got[k] = ps2_data__;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k + 1 == wr_at) cpu_write(16'h6001, 8'h00);
            if (k + 1 == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                check("rst_tx_active", {31'd0, tx_active}, 32'd0);
                check("rst_irq", {31'd0, sys_irq}, 32'd1);
                reset = 1'b0;
                return;
            end
        end
        if (nclk >= 11) begin
            dev_data_low = do_ack;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [9:0] got;
        int inh, rts, n, act_cnt;

        // Hand-computed frames pin the reference function itself.
        check("model_ED", {22'd0, frame_of(8'hED)}, 32'h3ED);
        check("model_F4", {22'd0, frame_of(8'hF4)}, 32'h2F4);
        check("model_00", {22'd0, frame_of(8'h00)}, 32'h300);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx_active", {31'd0, tx_active}, 32'd0);
        check("reset_irq", {31'd0, sys_irq}, 32'd1);
        cpu_read(16'h6000, rd);  check("reset_status", {24'd0, rd}, 32'h00);
        cpu_read(16'h6001, rd);  check("reset_data", {24'd0, rd}, 32'h00);

        // 0xED with ack; a second DATA write during BITS must be ignored.
        cpu_write(16'h6001, 8'hED);
        measure_inhibit(inh, rts);
        check("inhibit_cycles", inh, 32'd120);
        check("rts_cycles", rts, 32'd1);
        dev_frame(11, 1'b1, 4, 0, got);
        check("frame_ED", {22'd0, got}, {22'd0, frame_of(8'hED)});
        wait_idle(2000, n);
        cpu_read(16'h6000, rd);  check("status_done", {24'd0, rd}, 32'h40);
        check("irq_done", {31'd0, sys_irq}, 32'd0);
        cpu_read(16'h6001, rd);  check("data_kept_ED", {24'd0, rd}, 32'hED);
        cpu_write(16'h6000, 8'h00);
        cpu_read(16'h6000, rd);  check("status_cleared", {24'd0, rd}, 32'h00);
        check("irq_cleared", {31'd0, sys_irq}, 32'd1);

        // 0xF4 without ack.
        cpu_write(16'h6001, 8'hF4);
        dev_frame(11, 1'b0, 0, 0, got);
        check("frame_F4", {22'd0, got}, {22'd0, frame_of(8'hF4)});
        wait_idle(2000, n);
        cpu_read(16'h6000, rd);  check("status_failed", {24'd0, rd}, 32'h20);
        check("irq_failed", {31'd0, sys_irq}, 32'd0);
        cpu_write(16'h6000, 8'h00);

        // 0xFF, device stalls after 4 clocks.
        cpu_write(16'h6001, 8'hFF);
        dev_frame(4, 1'b0, 0, 0, got);
        check("timeout_still_busy", {31'd0, tx_active}, 32'd1);
        wait_idle(25000, n);
        check("timeout_window", {31'd0, (n >= 19850 && n <= 20000)}, 32'd1);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        cpu_read(16'h6000, rd);  check("status_timeout", {24'd0, rd}, 32'h10);
        check("irq_timeout", {31'd0, sys_irq}, 32'd1);

        // Reset at bit counter 5 abandons the frame.
        cpu_write(16'h6001, 8'hA5);
        dev_frame(11, 1'b1, 0, 5, got);
        repeat (2) @(negedge clk);
        cpu_read(16'h6000, rd);  check("status_after_rst", {24'd0, rd}, 32'h00);
        cpu_read(16'h6001, rd);  check("data_after_rst", {24'd0, rd}, 32'h00);

        // Write select held for 10 cycles sends exactly one frame.
        @(negedge clk);
        sys_adr = 16'h6001; sys_rw = 1'b0; sys_data_in = 8'h3C;
        repeat (10) @(negedge clk);
        sys_rw = 1'b1; sys_adr = 16'h0000;
        dev_frame(11, 1'b1, 0, 0, got);
        check("frame_3C", {22'd0, got}, {22'd0, frame_of(8'h3C)});
        wait_idle(2000, n);
        act_cnt = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_active) act_cnt++;
        end
        check("single_frame", act_cnt, 32'd0);
        cpu_read(16'h6000, rd);  check("status_hold_done", {24'd0, rd}, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
